bus_txn_master: RTL and testbench



---
 rtl/bus_txn_master.sv | 164 ++++++++++++++++
 tb/tb_bus_txn_master.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_txn_master.sv
// bus_txn_master: sequences one operand through the x5 bus slave.
// Ports: clk/rst_n; op_* in (valid/ready); res_* out (valid/ready);
//   DataBus shared tristate bus; write, link_bus slave controls; busy.
module bus_txn_master #(
    parameter int WIDTH       = 12,
    parameter int SETUP_CYC   = 1,
    parameter int WR_HIGH_CYC = 2,
    parameter int TURN_CYC    = 1,
    parameter int LINK_CYC    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op_data,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             res_valid,
    input  logic             res_ready,
    inout  wire  [WIDTH-1:0] DataBus,
    output logic             write,
    output logic             link_bus,
    output logic             busy
);

    localparam int CW = 8;
    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_WR    = CW'(WR_HIGH_CYC - 1);
    localparam logic [CW-1:0] LD_TURN  = CW'(TURN_CYC - 1);
    localparam logic [CW-1:0] LD_LINK  = CW'(LINK_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WRITE,
        TURN,
        LINK,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_accept;
    logic             w_sample;
    logic [WIDTH-1:0] r_op;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] w_exp;
    logic             r_drive;
    logic             r_write;
    logic             r_link;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_err;

    // x5 as shift-and-add, wrapping at WIDTH bits
    assign w_exp = (op_data << 2) + op_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        w_accept  = 1'b0;
        w_sample  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (op_valid) begin
                    w_accept  = 1'b1;
                    w_nxt     = DRIVE;
                    w_cnt_nxt = LD_SETUP;
                end
            end
            DRIVE: begin
                if (r_cnt == '0) begin
                    w_nxt     = WRITE;
                    w_cnt_nxt = LD_WR;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            WRITE: begin
                if (r_cnt == '0) begin
                    w_nxt     = TURN;
                    w_cnt_nxt = LD_TURN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            TURN: begin
                if (r_cnt == '0) begin
                    w_nxt     = LINK;
                    w_cnt_nxt = LD_LINK;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            LINK: begin
                if (r_cnt == '0) begin
                    w_nxt    = DONE;
                    w_sample = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_nxt = IDLE;
                end
            end
            default: w_nxt = IDLE;
        endcase
    end

    // Bus controls are decoded from the next state into flops so
    // they are glitch-free and drive/link can never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drive <= 1'b0;
            r_write <= 1'b0;
            r_link  <= 1'b0;
        end else begin
            r_drive <= (w_nxt == DRIVE) || (w_nxt == WRITE);
            r_write <= (w_nxt == WRITE);
            r_link  <= (w_nxt == LINK);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_exp      <= '0;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= op_data;
                r_exp <= w_exp;
            end
            if (w_sample) begin
                r_res_data <= DataBus;
                r_res_err  <= (DataBus != r_exp);
            end
        end
    end

    assign DataBus   = r_drive ? r_op : {WIDTH{1'bz}};
    assign write     = r_write;
    assign link_bus  = r_link;
    assign op_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign res_valid = (r_state == DONE);
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;

endmodule

// File: tb/tb_bus_txn_master.sv
// tb_bus_txn_master: directed bench for bus_txn_master with an
// x5 slave model on the shared bus.
module tb_bus_txn_master;

    logic        clk;
    logic        rst_n;
    logic [11:0] op_data;
    logic        op_valid;
    logic        op_ready;
    logic [11:0] res_data;
    logic        res_err;
    logic        res_valid;
    logic        res_ready;
    wire  [11:0] DataBus;
    logic        write;
    logic        link_bus;
    logic        busy;

    int n_vec;
    int n_bad;
    int n_contend;
    int n_xsamp;

    logic [11:0] slv_q;
    logic        ovr_en;
    logic [11:0] ovr_val;
    logic [11:0] slv_res;

    bus_txn_master dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_data  (op_data),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .res_data (res_data),
        .res_err  (res_err),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .DataBus  (DataBus),
        .write    (write),
        .link_bus (link_bus),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: capture on write rise, return x5 (or a forced value).
    initial slv_q = '0;
    always @(posedge write) slv_q <= DataBus;
    assign slv_res = ovr_en ? ovr_val : 12'((slv_q << 2) + slv_q);
    assign DataBus = link_bus ? slv_res : 12'bz;

    always @(negedge clk) begin
        if (rst_n && dut.r_drive && link_bus) n_contend++;
        if (rst_n && link_bus && $isunknown(DataBus)) n_xsamp++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] op);
        for (int k = 0; k < 20 && !op_ready; k++) tick();
        chk("op_ready_to", 32'(op_ready), 32'd1);
        op_data  = op;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic wait_rv();
        for (int k = 0; k < 20 && !res_valid; k++) tick();
        chk("res_valid_to", 32'(res_valid), 32'd1);
    endtask

    task automatic do_txn(input logic [11:0] op, input logic [11:0] ed,
                          input logic ee);
        send(op);
        wait_rv();
        chk("res_data", 32'(res_data), 32'(ed));
        chk("res_err", 32'(res_err), 32'(ee));
        tick();
    endtask

    initial begin
        logic [7:0]  ew;
        logic [7:0]  el;
        logic [7:0]  ev;
        logic [7:0]  er;
        logic [11:0] r;
        int          rv_cnt;

        n_vec     = 0;
        n_bad     = 0;
        n_contend = 0;
        n_xsamp   = 0;
        ovr_en    = 1'b0;
        ovr_val   = '0;
        op_data   = '0;
        op_valid  = 1'b0;
        res_ready = 1'b1;
        rst_n     = 1'b0;
        #3;
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_link", 32'(link_bus), 32'd0);
        chk("rst_rv", 32'(res_valid), 32'd0);
        chk("rst_rdata", 32'(res_data), 32'd0);
        chk("rst_rerr", 32'(res_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_op_ready", 32'(op_ready), 32'd1);

        // Cycle-accurate timeline, cycles 1..8 after the accept edge
        ew = 8'b0000_0110;
        el = 8'b0011_0000;
        ev = 8'b0100_0000;
        er = 8'b1000_0000;
        send(12'h001);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("tl_write_c%0d", c + 1), 32'(write),
                32'(ew[c]));
            chk($sformatf("tl_link_c%0d", c + 1), 32'(link_bus),
                32'(el[c]));
            chk($sformatf("tl_rv_c%0d", c + 1), 32'(res_valid),
                32'(ev[c]));
            chk($sformatf("tl_ordy_c%0d", c + 1), 32'(op_ready),
                32'(er[c]));
            if (c == 6) begin
                chk("tl_rdata", 32'(res_data), 32'h005);
                chk("tl_rerr", 32'(res_err), 32'd0);
            end
            if (c < 7) tick();
        end

        do_txn(12'hFFF, 12'hFFB, 1'b0);
        do_txn(12'h000, 12'h000, 1'b0);

        // Backpressure with a second operand pending
        res_ready = 1'b0;
        send(12'h0AB);
        wait_rv();
        chk("bp_rdata", 32'(res_data), 32'h357);
        op_data  = 12'h00C;
        op_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_rv_hold", 32'(res_valid), 32'd1);
            chk("bp_rdata_hold", 32'(res_data), 32'h357);
            chk("bp_ordy", 32'(op_ready), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_idle_ordy", 32'(op_ready), 32'd1);
        tick();
        op_valid = 1'b0;
        chk("bp_accepted", 32'(busy), 32'd1);
        wait_rv();
        chk("bp_second", 32'(res_data), 32'h03C);
        chk("bp_second_err", 32'(res_err), 32'd0);
        tick();

        // Bad slave response
        ovr_en  = 1'b1;
        ovr_val = 12'h123;
        do_txn(12'h010, 12'h123, 1'b1);
        ovr_en  = 1'b0;

        // Reset during the first WRITE cycle
        send(12'h055);
        tick();
        chk("ra_write_pre", 32'(write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra_write", 32'(write), 32'd0);
        chk("ra_link", 32'(link_bus), 32'd0);
        chk("ra_drive", 32'(dut.r_drive), 32'd0);
        chk("ra_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        rv_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (res_valid) rv_cnt++;
        end
        chk("ra_no_result", 32'(rv_cnt), 32'd0);
        do_txn(12'h055, 12'h1A9, 1'b0);

        // Back-to-back random operands
        for (int k = 0; k < 20; k++) begin
            r = 12'($urandom);
            do_txn(r, 12'((32'(r) * 5) & 32'hFFF), 1'b0);
        end

        chk("contention_cycles", 32'(n_contend), 32'd0);
        chk("x_on_link", 32'(n_xsamp), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
